// File: rtl/saw_voice_bank.sv
// saw_voice_bank
//   Multi-voice sawtooth generator. NUM_VOICES phase accumulators share one
//   adder and are scanned one voice per clock at the start of every sample
//   period. Gated voices are summed, the sum is scaled by 1/NUM_VOICES, and
//   the resulting sample drives a first-order sigma-delta bitstream.
//
// Ports
//   clk           system clock
//   rst           synchronous reset, active-high
//   wr_en         register write strobe (one cycle)
//   wr_addr       register address: 0..NUM_VOICES-1 -> inc[addr], 16 -> gate mask
//   wr_data       register write data
//   sample_out    current mixed sample
//   sample_valid  one-cycle pulse when sample_out updates
//   busy          high while the voice scan is in progress
//   data          sigma-delta bitstream
//
// state | meaning
// IDLE  | wait for the sample counter to reach 0
// SCAN  | one voice per cycle, idx 0..NUM_VOICES-1, accumulating the mix
// MIX   | scale the accumulated mix into sample_out, pulse sample_valid

module saw_voice_bank #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 16,
  parameter int OUT_W      = 8,
  parameter int SAMPLE_DIV = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [4:0]         wr_addr,
  input  logic [PHASE_W-1:0] wr_data,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               data
);

  localparam int SH    = $clog2(NUM_VOICES);
  localparam int VW    = (NUM_VOICES > 1) ? SH : 1;
  localparam int ACC_W = OUT_W + SH;
  localparam int CNT_W = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_MIX} state_t;

  state_t                  state;
  logic [VW-1:0]           idx;
  logic [CNT_W-1:0]        cnt;
  logic [ACC_W-1:0]        acc;
  logic [PHASE_W-1:0]      phase [NUM_VOICES];
  logic [PHASE_W-1:0]      inc   [NUM_VOICES];
  logic [NUM_VOICES-1:0]   gate;
  logic [NUM_VOICES-1:0]   gate_prev;
  logic [OUT_W-1:0]        err;
  logic [OUT_W:0]          sd_sum;

  // Selected voice for the shared adder; a compare-based mux keeps the
  // NUM_VOICES==1 case free of zero-width index expressions.
  logic [PHASE_W-1:0]      cur_phase;
  logic                    cur_gate;
  logic                    cur_prev;
  logic [OUT_W-1:0]        contrib;

  always_comb begin
    cur_phase = '0;
    cur_gate  = 1'b0;
    cur_prev  = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (idx == VW'(i)) begin
        cur_phase = phase[i];
        cur_gate  = gate[i];
        cur_prev  = gate_prev[i];
      end
    end
  end

  // Only a voice whose gate was already open contributes; a rising gate
  // hard-syncs the phase and contributes 0 for that sample.
  assign contrib = (cur_gate && cur_prev) ? cur_phase[PHASE_W-1 -: OUT_W] : '0;

  assign sd_sum = {1'b0, err} + {1'b0, sample_out};

  // Register port
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) inc[i] <= '0;
      gate <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (wr_addr == 5'(i)) inc[i] <= wr_data;
      end
      if (wr_addr == 5'd16) gate <= wr_data[NUM_VOICES-1:0];
    end
  end

  // Phase accumulators, updated only for the voice currently being scanned
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_VOICES; i++) phase[i] <= '0;
      gate_prev <= '0;
    end else if (state == S_SCAN) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (idx == VW'(i)) begin
          gate_prev[i] <= gate[i];
          if (gate[i] && !gate_prev[i]) phase[i] <= '0;
          else if (gate[i])             phase[i] <= phase[i] + inc[i];
        end
      end
    end
  end

  // Sample counter, scan FSM and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      cnt          <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cnt          <= (cnt == CNT_W'(SAMPLE_DIV - 1)) ? '0 : cnt + 1'b1;
      sample_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cnt == '0) begin
            state <= S_SCAN;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        S_SCAN: begin
          acc <= acc + ACC_W'(contrib);
          if (idx == VW'(NUM_VOICES - 1)) begin
            state <= S_MIX;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_MIX: begin
          sample_out   <= OUT_W'(acc >> SH);
          sample_valid <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // First-order sigma-delta: the carry out of the error accumulator is the bit
  always_ff @(posedge clk) begin
    if (rst) begin
      err  <= '0;
      data <= 1'b0;
    end else begin
      err  <= sd_sum[OUT_W-1:0];
      data <= sd_sum[OUT_W];
    end
  end

endmodule

// File: tb/tb_saw_voice_bank.sv
// Testbench for saw_voice_bank: instance a (4 voices, 16-cycle period) covers
// reset, ramps, all-voice mixing, hard sync, bad address and reset mid-scan;
// instance b (1 voice, 256-cycle period) covers sigma-delta density.
module tb_saw_voice_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, wr_en_a = 1'b0;
  logic [4:0]  wr_addr_a = '0;
  logic [15:0] wr_data_a = '0;
  logic [7:0]  sample_a;
  logic        valid_a, busy_a, data_a;

  logic        rst_b = 1'b1, wr_en_b = 1'b0;
  logic [4:0]  wr_addr_b = '0;
  logic [15:0] wr_data_b = '0;
  logic [7:0]  sample_b;
  logic        valid_b, busy_b, data_b;

  saw_voice_bank #(.NUM_VOICES(4), .PHASE_W(16), .OUT_W(8), .SAMPLE_DIV(16)) dut_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .sample_out(sample_a), .sample_valid(valid_a), .busy(busy_a), .data(data_a));

  saw_voice_bank #(.NUM_VOICES(1), .PHASE_W(16), .OUT_W(8), .SAMPLE_DIV(256)) dut_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .sample_out(sample_b), .sample_valid(valid_b), .busy(busy_b), .data(data_b));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: a sample is checked whenever one is expected.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_a && valid_a && exp_a.size() > 0) begin
      e = exp_a.pop_front();
      check("sample_a", int'(sample_a), int'(e));
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_b && valid_b && exp_b.size() > 0) begin
      e = exp_b.pop_front();
      check("sample_b", int'(sample_b), int'(e));
    end
  end

  task automatic write_a(input logic [4:0] addr, input logic [15:0] wdata);
    wr_en_a = 1'b1; wr_addr_a = addr; wr_data_a = wdata;
    @(negedge clk);
    wr_en_a = 1'b0;
  endtask

  task automatic write_b(input logic [4:0] addr, input logic [15:0] wdata);
    wr_en_b = 1'b1; wr_addr_b = addr; wr_data_b = wdata;
    @(negedge clk);
    wr_en_b = 1'b0;
  endtask

  task automatic reset_a(input int n);
    rst_a = 1'b1;
    repeat (n) @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic wait_valid_a(input int max);
    int t = 0;
    do begin @(negedge clk); t++; end while (!valid_a && t < max);
    if (!valid_a) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_valid_a: no sample_valid within %0d cycles, expected one", max);
    end
  endtask

  task automatic wait_valid_b(input int max);
    int t = 0;
    do begin @(negedge clk); t++; end while (!valid_b && t < max);
    if (!valid_b) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_valid_b: no sample_valid within %0d cycles, expected one", max);
    end
  endtask

  task automatic drain_a(input int max);
    int t = 0;
    while (exp_a.size() > 0 && t < max) begin @(negedge clk); t++; end
    if (exp_a.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_a: %0d samples outstanding, expected 0", exp_a.size());
      exp_a.delete();
    end
  endtask

  task automatic drain_b(input int max);
    int t = 0;
    while (exp_b.size() > 0 && t < max) begin @(negedge clk); t++; end
    if (exp_b.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_b: %0d samples outstanding, expected 0", exp_b.size());
      exp_b.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_n, last_v, first_v, ones, vcount, t;
    logic pb;

    // ---- Test 1: reset and idle timing ----
    repeat (20) @(negedge clk);
    check("rst_sample", int'(sample_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_data", int'(data_a), 0);
    rst_a = 1'b0;
    for (int k = 0; k < 6; k++) exp_a.push_back(8'h00);
    rise_n = -100; last_v = -1; first_v = -1; ones = 0; pb = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      ones += int'(data_a);
      if (busy_a && !pb) rise_n = n;
      if (!busy_a && pb) check("busy_len", n - rise_n, 4);
      if (valid_a) begin
        check("valid_after_busy", n - rise_n, 5);
        if (last_v >= 0) check("valid_period", n - last_v, 16);
        else first_v = n;
        last_v = n;
      end
      pb = busy_a;
    end
    check("first_valid", first_v, 5);
    check("data_idle_ones", ones, 0);
    drain_a(40);

    // ---- Test 2: single voice ramp ----
    reset_a(3);
    wait_valid_a(40);
    write_a(5'd0, 16'h1000);
    write_a(5'd16, 16'h0001);
    exp_a.push_back(8'h00);
    for (int k = 2; k <= 18; k++) exp_a.push_back(8'((((k - 2) * 16) % 256) / 4));
    drain_a(19 * 16 + 40);

    // ---- Test 3: all voices ----
    reset_a(3);
    wait_valid_a(40);
    for (int i = 0; i < 4; i++) write_a(5'(i), 16'h4000);
    write_a(5'd16, 16'h000F);
    exp_a.push_back(8'h00); exp_a.push_back(8'h00); exp_a.push_back(8'h40);
    exp_a.push_back(8'h80); exp_a.push_back(8'hC0); exp_a.push_back(8'h00);
    exp_a.push_back(8'h40); exp_a.push_back(8'h80);
    drain_a(9 * 16 + 40);

    // ---- Test 4: hard sync (voice 0 reaches phase 0x5000, then gated) ----
    reset_a(3);
    wait_valid_a(40);
    write_a(5'd0, 16'h1000);
    write_a(5'd16, 16'h0001);
    exp_a.push_back(8'h00); exp_a.push_back(8'h00); exp_a.push_back(8'h04);
    exp_a.push_back(8'h08); exp_a.push_back(8'h0C); exp_a.push_back(8'h10);
    drain_a(7 * 16 + 40);
    write_a(5'd16, 16'h0000);
    exp_a.push_back(8'h00);
    drain_a(2 * 16 + 40);
    write_a(5'd16, 16'h0001);
    exp_a.push_back(8'h00); exp_a.push_back(8'h00); exp_a.push_back(8'h04);
    drain_a(4 * 16 + 40);

    // ---- Test 6a: unmapped address 7 must not alias onto inc[3] ----
    reset_a(3);
    wait_valid_a(40);
    write_a(5'd0, 16'h4000);
    write_a(5'd7, 16'hFFFF);
    write_a(5'd16, 16'h0009);
    exp_a.push_back(8'h00); exp_a.push_back(8'h00); exp_a.push_back(8'h10);
    exp_a.push_back(8'h20); exp_a.push_back(8'h30); exp_a.push_back(8'h00);
    drain_a(7 * 16 + 40);

    // ---- Test 6b: reset while idx==2 ----
    t = 0;
    while (!busy_a && t < 40) begin @(negedge clk); t++; end
    check("busy_seen", int'(busy_a), 1);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("midscan_busy", int'(busy_a), 0);
    check("midscan_sample", int'(sample_a), 0);
    rst_a = 1'b0;
    vcount = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      vcount += int'(valid_a);
    end
    check("midscan_no_valid", vcount, 0);
    wait_valid_a(40);
    write_a(5'd0, 16'h4000);
    write_a(5'd16, 16'h0009);
    exp_a.push_back(8'h00); exp_a.push_back(8'h00); exp_a.push_back(8'h10);
    exp_a.push_back(8'h20);
    drain_a(5 * 16 + 40);

    // ---- Test 5: sigma-delta density on the 1-voice, 256-cycle instance ----
    repeat (5) @(negedge clk);
    rst_b = 1'b0;
    ones = 0;
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      ones += int'(data_b);
    end
    check("sd_zero_ones", ones, 0);
    wait_valid_b(300);
    write_b(5'd0, 16'h6000);
    write_b(5'd16, 16'h0001);
    exp_b.push_back(8'h00); exp_b.push_back(8'h00);
    drain_b(3 * 256 + 40);
    write_b(5'd0, 16'h0000);
    exp_b.push_back(8'h60);
    drain_b(2 * 256 + 40);
    exp_b.push_back(8'h60);
    ones = 0;
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      ones += int'(data_b);
    end
    n_cmp++;
    if (ones < 95 || ones > 97) begin
      n_bad++;
      $display("FAIL sd_density: got %0d ones, expected 96 +/-1", ones);
    end
    drain_b(2 * 256 + 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
